// File: rtl/parallax_pkg.sv
// Shared constants, raster flag bundle and scroll arithmetic for the parallax sequencer.
// Default timing is 640x480@60 with a 25.175 MHz pixel clock.
package parallax_pkg;

  localparam int COORD_W  = 10;
  localparam int SPEED_W  = 3;
  localparam int SCROLL_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_LAYERS   = 3;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Per-pixel decode results, registered together so they stay aligned with x/y.
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic line_start;
    logic frame_start;
  } raster_flags_t;

  // Decode of the last position of a frame: blanked, syncs idle, no strobes.
  localparam raster_flags_t FLAGS_IDLE = '{
    de:          1'b0,
    hsync:       1'b1,
    vsync:       1'b1,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  // cur < limit and step <= 7 < limit, so one conditional subtract keeps the result in range.
  function automatic logic [SCROLL_W-1:0] scroll_step(
    input logic [SCROLL_W-1:0] cur,
    input logic [SPEED_W-1:0]  step,
    input logic [SCROLL_W-1:0] limit
  );
    logic [SCROLL_W:0] sum;
    sum = {1'b0, cur} + {{(SCROLL_W + 1 - SPEED_W){1'b0}}, step};
    if (sum >= {1'b0, limit}) begin
      sum = sum - {1'b0, limit};
    end
    return sum[SCROLL_W-1:0];
  endfunction

endpackage

// File: rtl/parallax_layer_scroll.sv
// One background layer's horizontal scroll offset, advanced modulo H_ACTIVE
// on the once-per-frame update strobe unless paused.
module parallax_layer_scroll
  import parallax_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                update,
  input  logic                pause,
  input  logic [SPEED_W-1:0]  speed,
  output logic [SCROLL_W-1:0] scroll
);

  localparam logic [SCROLL_W-1:0] LIMIT = SCROLL_W'(H_ACTIVE);

  logic [SCROLL_W-1:0] scroll_reg;
  logic [SCROLL_W-1:0] scroll_next;

  // speed and pause only matter in the cycle the strobe is high.
  always_comb begin
    scroll_next = scroll_reg;
    if (update && !pause) begin
      scroll_next = scroll_step(scroll_reg, speed, LIMIT);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scroll_reg <= '0;
    end else begin
      scroll_reg <= scroll_next;
    end
  end

  assign scroll = scroll_reg;

endmodule

// File: rtl/parallax_sequencer.sv
// Raster timing generator plus per-layer scroll offsets for the parallax renderer.
// Every output is a register describing the position currently shown on x/y.
module parallax_sequencer
  import parallax_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int LAYERS   = DEF_LAYERS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pause,
  input  logic [SPEED_W*LAYERS-1:0]  speed,
  output logic [COORD_W-1:0]         x,
  output logic [COORD_W-1:0]         y,
  output logic                       de,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       line_start,
  output logic                       frame_start,
  output logic [SCROLL_W*LAYERS-1:0] scroll
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEGIN = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEGIN = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COORD_W-1:0] V_PRE_UPD = COORD_W'(V_ACTIVE - 1);

  logic [COORD_W-1:0] x_reg, x_next;
  logic [COORD_W-1:0] y_reg, y_next;
  raster_flags_t      flags_reg, flags_next;
  logic               update;

  // Flags are decoded from the next position so they land in the same cycle as x/y.
  always_comb begin
    x_next = x_reg + COORD_W'(1);
    y_next = y_reg;
    if (x_reg == H_LAST) begin
      x_next = '0;
      y_next = (y_reg == V_LAST) ? '0 : y_reg + COORD_W'(1);
    end

    flags_next             = FLAGS_IDLE;
    flags_next.de          = (x_next < H_ACT_C) && (y_next < V_ACT_C);
    flags_next.hsync       = !((x_next >= HS_BEGIN) && (x_next < HS_END));
    flags_next.vsync       = !((y_next >= VS_BEGIN) && (y_next < VS_END));
    flags_next.line_start  = (x_next == '0);
    flags_next.frame_start = (x_next == '0) && (y_next == '0);

    // High in the cycle whose closing edge moves the raster onto (0, V_ACTIVE).
    update = (x_reg == H_LAST) && (y_reg == V_PRE_UPD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg     <= H_LAST;
      y_reg     <= V_LAST;
      flags_reg <= FLAGS_IDLE;
    end else begin
      x_reg     <= x_next;
      y_reg     <= y_next;
      flags_reg <= flags_next;
    end
  end

  assign x           = x_reg;
  assign y           = y_reg;
  assign de          = flags_reg.de;
  assign hsync       = flags_reg.hsync;
  assign vsync       = flags_reg.vsync;
  assign line_start  = flags_reg.line_start;
  assign frame_start = flags_reg.frame_start;

  for (genvar gi = 0; gi < LAYERS; gi++) begin : g_layer
    parallax_layer_scroll #(
      .H_ACTIVE(H_ACTIVE)
    ) u_layer (
      .clk    (clk),
      .reset  (reset),
      .update (update),
      .pause  (pause),
      .speed  (speed[SPEED_W*gi +: SPEED_W]),
      .scroll (scroll[SCROLL_W*gi +: SCROLL_W])
    );
  end

endmodule

// File: doc/parallax_sequencer.md
# parallax_sequencer

Frame sequencer for the parallax VGA renderer. It generates the 640x480@60 raster timing: pixel position, display enable, sync pulses, and line/frame strobes. Once per frame it advances a horizontal scroll offset for each background layer at a per-layer speed. The renderer consumes the position and offsets; hsync/vsync go straight to the pads.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch
- H_SYNC, 96: hsync pulse width
- H_BP, 48: horizontal back porch
- V_ACTIVE, 480: visible lines
- V_FP, 10: vertical front porch
- V_SYNC, 2: vsync pulse width
- V_BP, 33: vertical back porch
- LAYERS, 3: number of scrolling layers

Ports:
- clk  in  1  pixel clock; the system clock in the codebase.
- reset  in  1  asynchronous, active-high.
- pause  in  1  high inhibits the scroll advance at the next update point.
- speed  in  3*LAYERS  per-layer step, 0..7 pixels/frame; layer k uses bits [3k+2:3k].
- x  out  10  horizontal position counter.
- y  out  10  vertical position counter.
- de  out  1  high when x < H_ACTIVE and y < V_ACTIVE.
- hsync  out  1  active-low sync pulse.
- vsync  out  1  active-low sync pulse.
- line_start  out  1  high for one cycle when x == 0.
- frame_start  out  1  high for one cycle when x == 0 and y == 0.
- scroll  out  10*LAYERS  layer k offset in bits [10k+9:10k], range 0..H_ACTIVE-1.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- x counts 0..H_TOTAL-1 and wraps to 0. y increments when x wraps, counts 0..V_TOTAL-1 and wraps to 0.
- hsync = 0 iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- vsync = 0 iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- vsync depends only on y. It therefore changes on x == 0 edges only.
- Alignment: de, hsync, vsync, line_start, frame_start and scroll all describe the position shown on x/y in the same cycle. No output lags another.
- Scroll update point: the rising edge on which the position becomes (x=0, y=V_ACTIVE), the first blanked line.
  - On that edge, for each layer k: scroll_k ← scroll_k + speed_k. If the sum is ≥ H_ACTIVE, subtract H_ACTIVE.
  - speed and pause are sampled only on that edge. Changes at any other time have no effect.
  - If pause is high on that edge, every scroll_k holds.
  - speed_k = 0 holds that layer.
- scroll is therefore constant throughout active video. It changes at most once per frame.
- All layers update in the same cycle.

## Timing
- Every output is driven from a register. No combinational path exists from the inputs to any output.
- Reset values, held while reset is high:
  - x = H_TOTAL-1 (799), y = V_TOTAL-1 (524).
  - de = 0, hsync = 1, vsync = 1.
  - line_start = 0, frame_start = 0.
  - scroll = 0 for all layers.
- These reset values are exactly the decode of position (799,524), so outputs are consistent during reset.
- First rising edge after reset deasserts: x=0, y=0, de=1, line_start=1, frame_start=1.
- Frame period is H_TOTAL*V_TOTAL = 420000 cycles. Line period is 800 cycles.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronous). Scroll progress is discarded.
- Wrap-around example: scroll=636, step=7 gives 3, not 643. Any sum up to 639+7 needs only one conditional subtract.
- Constraints: speed ≤ 7 by width. H_TOTAL and V_TOTAL must be ≤ 1024 (10-bit counters).

## Structure
- Shared package parallax_pkg:
  - default timing constants and derived H_TOTAL/V_TOTAL;
  - COORD_W = 10, SPEED_W = 3, SCROLL_W = 10;
  - LAYERS default.
- Sub-module parallax_layer_scroll, instantiated once per layer via generate.
  - Inputs: clk, reset, update strobe, pause, speed_k.
  - Output: scroll_k.
  - Contains the modular-add register.
- The top level holds the raster counters, the sync/de/strobe decode registers, and generation of the update strobe.

## Test plan
- Reset release: hold reset 5 cycles, then deassert. Reset values during reset are exact. First post-reset cycle shows x=0, y=0, de=1, frame_start=1. frame_start recurs exactly 420000 cycles later.
- Sync geometry over one frame:
  - hsync low for 96 cycles starting at x=656 on every line.
  - vsync low on y=490 and y=491 only.
  - de high for 640*480 = 307200 cycles.
  - line_start count = 525.
- Scroll stepping: speed = {3'd1, 3'd4, 3'd7}, pause = 0, run 3 frames. Layers 0/1/2 read 7/4/1 after the first update, 14/8/2 after the second and 21/12/3 after the third. Each change happens on the edge to (0,480) only.
- Wrap-around: speed = 7 for all layers, run 92 frames. Offsets go 637 → 4 at the update after frame 91 (644-640). Values never reach ≥ 640.
- Sampling window and pause:
  - Toggle speed mid-active-video and change it back before y=480: no effect.
  - Hold pause = 1 across one update point: scroll unchanged for that frame.
  - Pulse pause = 1 at any other time: next update advances normally.
- Mid-frame reset: assert reset at (x=300, y=200) with nonzero scroll. All outputs take their reset values asynchronously, before the next clock edge. Recovery matches the reset-release scenario.
